// File: rtl/ysyx_22050518_lsu_if.sv
// ysyx_22050518_lsu_if: data-memory request/response bundle between
// the LSU (master) and the memory responder (slave).
interface ysyx_22050518_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_skip;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wstrb,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_skip
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wstrb,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_skip
    );
endinterface

// File: rtl/ysyx_22050518_lsu.sv
// ysyx_22050518_lsu: one-op-at-a-time load/store unit for the NPC core.
// Optional YSYX_22050518_LSU_MISALIGN_CHK_EN rejects misaligned ops in IDLE.
module ysyx_22050518_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_we,
    input  logic [1:0]                in_size,
    input  logic                      in_signed,
    input  logic [63:0]               in_addr,
    input  logic [63:0]               in_wdata,
    ysyx_22050518_lsu_if.master       mem,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_data,
    output logic                      out_skip_ref,
    output logic                      out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic        we_q, signed_q, skip_q, err_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q, data_q;
    logic [31:0] cnt;

    logic [2:0]  off;
    logic [5:0]  shamt;
    logic [7:0]  mask;
    logic [15:0] strb_w;
    logic [63:0] raw, ext;
    logic        misalign, to_hit;

    assign off   = addr_q[2:0];
    assign shamt = {off, 3'b000};

    always_comb begin
        mask = 8'h00;
        case (size_q)
            2'd0:    mask = 8'h01;
            2'd1:    mask = 8'h03;
            2'd2:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 simply fall off the top.
    assign strb_w = {8'h00, mask} << off;
    assign raw    = mem.resp_data >> shamt;

    always_comb begin
        ext = raw;
        case (size_q)
            2'd0: ext = signed_q ? {{56{raw[7]}}, raw[7:0]}
                                 : {56'd0, raw[7:0]};
            2'd1: ext = signed_q ? {{48{raw[15]}}, raw[15:0]}
                                 : {48'd0, raw[15:0]};
            2'd2: ext = signed_q ? {{32{raw[31]}}, raw[31:0]}
                                 : {32'd0, raw[31:0]};
            default: ext = raw;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
`ifdef YSYX_22050518_LSU_MISALIGN_CHK_EN
        unique case (in_size)
            2'd0: misalign = 1'b0;
            2'd1: misalign = in_addr[0];
            2'd2: misalign = |in_addr[1:0];
            2'd3: misalign = |in_addr[2:0];
        endcase
`else
        misalign = 1'b0;
`endif
    end

    assign to_hit = (TIMEOUT_CYCLES != 0) &&
                    (cnt == TIMEOUT_CYCLES - 32'd1);

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign out_data      = data_q;
    assign out_skip_ref  = skip_q;
    assign out_err       = err_q;
    assign mem.req_valid = (state == REQ);
    assign mem.req_we    = we_q;
    assign mem.req_addr  = {addr_q[63:3], 3'b000};
    assign mem.req_wstrb = we_q ? strb_w[7:0] : 8'h00;
    assign mem.req_wdata = wdata_q << shamt;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (in_valid) state_n = misalign ? DONE : REQ;
            REQ:  if (mem.req_ready) state_n = WAIT;
            WAIT: if (mem.resp_valid || to_hit) state_n = DONE;
            DONE: if (out_ready) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            data_q   <= 64'd0;
            skip_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= 32'd0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    we_q     <= in_we;
                    signed_q <= in_signed;
                    size_q   <= in_size;
                    addr_q   <= in_addr;
                    wdata_q  <= in_wdata;
                    data_q   <= 64'd0;
                    skip_q   <= 1'b0;
                    err_q    <= misalign;
                end
                REQ: if (mem.req_ready) cnt <= 32'd0;
                WAIT: begin
                    cnt <= cnt + 32'd1;
                    if (mem.resp_valid) begin
                        data_q <= we_q ? 64'd0 : ext;
                        skip_q <= mem.resp_skip;
                        err_q  <= 1'b0;
                    end else if (to_hit) begin
                        data_q <= 64'd0;
                        skip_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: doc/ysyx_22050518_lsu.md
# ysyx_22050518_lsu

Load/store unit: the initiator end of the data-memory port in the NPC core. It accepts one memory op at a time from the execute stage and issues a single 8-byte-aligned request to the memory responder. It waits for the response, then hands the completed result, together with the responder's difftest-skip flag, to write-back. It does byte-lane steering, strobe generation and sign/zero extension.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, maximum number of cycles in WAIT before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  execute stage presents an op.
- in_ready  out  1  LSU accepts an op.
- in_we  in  1  1 = store, 0 = load.
- in_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- in_signed  in  1  sign-extend load result; ignored for stores.
- in_addr  in  64  byte address.
- in_wdata  in  64  store data, right-aligned.
- mem_req_valid  out  1  request to the memory responder.
- mem_req_ready  in  1  responder accepts the request.
- mem_req_we  out  1  write request.
- mem_req_addr  out  64  {addr[63:3], 3'b0}.
- mem_req_wstrb  out  8  byte strobes; 0 for loads.
- mem_req_wdata  out  64  store data shifted into its byte lanes.
- mem_resp_valid  in  1  response or write acknowledge.
- mem_resp_data  in  64  aligned 8-byte read data.
- mem_resp_skip  in  1  responder flags the access as device/MMIO.
- out_valid  out  1  completed op for write-back.
- out_ready  in  1  write-back accepts the result.
- out_data  out  64  extended load result; 0 for stores and errors.
- out_skip_ref  out  1  difftest must skip this instruction.
- out_err  out  1  bus timeout or misaligned access.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch we, size, signed, addr and wdata.
  - Go to REQ, or go directly to DONE with out_err = 1 if the misalign check rejects the op (see Configuration).
- REQ:
  - mem_req_valid = 1; request fields are held stable.
  - On mem_req_ready, go to WAIT and clear the timeout counter.
- WAIT:
  - The counter increments every cycle.
  - On mem_resp_valid, latch the result and mem_resp_skip, then go to DONE.
  - If TIMEOUT_CYCLES ≠ 0 and the counter reaches TIMEOUT_CYCLES with no response, go to DONE with out_err = 1, out_data = 0, out_skip_ref = 0.
  - Stores also wait for mem_resp_valid, which acts as the write acknowledge; the response data is ignored for stores.
- DONE:
  - out_valid = 1; outputs are held stable.
  - On out_ready, go to IDLE.
- Lane arithmetic, with off = addr[2:0]:
  - wstrb = (((1 << (1 << size)) − 1) << off)[7:0].
  - wdata = in_wdata << (8·off).
  - load raw = mem_resp_data >> (8·off), truncated to 8/16/32/64 bits, then sign-extended if in_signed, else zero-extended.
- mem_resp_valid is ignored outside WAIT.
- in_valid is ignored outside IDLE; there is no same-cycle DONE→accept bypass.

## Timing
- Reset, asynchronous: state = IDLE, timeout counter = 0, all registered outputs = 0. in_ready reads 1 once rst_n is high.
- Minimum latency, with mem_req_ready and mem_resp_valid each high on the first possible cycle:
  - accept edge → REQ (1 cycle);
  - → WAIT (1 cycle);
  - → DONE (1 cycle).
  - out_valid is asserted 3 cycles after the accept edge.
- Misaligned reject (macro defined): out_valid is asserted 1 cycle after accept, and no memory request is issued.
- Reset mid-operation abandons the access. A late mem_resp_valid after reset is ignored, because the FSM is in IDLE.
- Throughput: at most one op per 4 cycles.

## Configuration
- YSYX_22050518_LSU_MISALIGN_CHK_EN
  - Defined: an access with addr not a multiple of its size (half: addr[0] ≠ 0; word: addr[1:0] ≠ 0; dword: addr[2:0] ≠ 0) is rejected in IDLE. The FSM goes to DONE with out_err = 1, out_data = 0, out_skip_ref = 0, and no memory request is issued.
  - Undefined: no check is made and the access is always issued. Strobe bits above bit 7 are dropped, and load bytes beyond lane 7 read as 0; no err is raised for misalignment.

## Test plan
- Load byte, signed: addr = 0x8000_0003, mem_resp_data = 0x0000_0000_8000_0000 → mem_req_addr = 0x8000_0000, wstrb = 0x00, out_data = 0xFFFF_FFFF_FFFF_FF80.
- Load half, unsigned: addr = 0x8000_0006, mem_resp_data = 0xBEEF_0000_0000_0000 → out_data = 0x0000_0000_0000_BEEF.
- Store word: addr = 0x8000_0004, in_wdata = 0x1122_3344_5566_7788 → wstrb = 0xF0, wdata = 0x5566_7788_0000_0000. out_valid is asserted only after mem_resp_valid; out_data = 0.
- MMIO skip with backpressure: mem_resp_skip = 1 and out_ready held low for 5 cycles → out_skip_ref = 1 and out_valid/out_data stay stable for all 5 cycles. in_ready stays 0 until the cycle after out_ready.
- Timeout: TIMEOUT_CYCLES = 4, no mem_resp_valid → DONE is reached 4 cycles after entering WAIT with out_err = 1. A mem_resp_valid arriving later is ignored.
- Misaligned word at 0x8000_0002, macro defined → no mem_req_valid, out_err = 1 one cycle after accept. Same op with the macro undefined → request issued with wstrb = 0x3C.
